// File: rtl/inst_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// writes them to consecutive RAM addresses from 0, and holds the CPU in reset until done.
module inst_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              cpu_reset,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   word_cnt_r;
  logic [1:0]        byte_idx_r;
  logic [ADDR_W-1:0] addra_r;
  logic [31:0]       dina_r;
  logic [23:0]       buf_r;
  logic [ADDR_W:0]   len_clamp_s;
  logic [ADDR_W:0]   word_cnt_next_s;

  // Clamp requested length to RAM depth and precompute the post-write word count.
  always_comb begin
    len_clamp_s     = len;
    word_cnt_next_s = word_cnt_r + CNT_ONE;
    if (len > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = len;
    end
  end

  // Load FSM; the first three bytes are staged so dina only changes when a full word is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      len_r      <= '0;
      word_cnt_r <= '0;
      byte_idx_r <= 2'd0;
      addra_r    <= '0;
      dina_r     <= 32'h0000_0000;
      buf_r      <= 24'h00_0000;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            len_r      <= len_clamp_s;
            word_cnt_r <= '0;
            byte_idx_r <= 2'd0;
            addra_r    <= '0;
            state_r    <= (len_clamp_s == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0:    buf_r[7:0]   <= byte_in;
              2'd1:    buf_r[15:8]  <= byte_in;
              2'd2:    buf_r[23:16] <= byte_in;
              default: begin
                dina_r  <= {byte_in, buf_r};
                state_r <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          word_cnt_r <= word_cnt_next_s;
          addra_r    <= addra_r + ADDR_ONE;
          state_r    <= (word_cnt_next_s == len_r) ? DONE : LOAD;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign byte_ready = (state_r == LOAD);
  assign wea        = (state_r == WRITE);
  assign cpu_reset  = (state_r != DONE);
  assign done       = (state_r == DONE);
  assign addra      = addra_r;
  assign dina       = dina_r;
  assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader: writes are captured at the falling edge
// and compared against hand-computed words and addresses.
module tb_inst_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              cpu_reset;
  logic              done;
  logic [ADDR_W:0]   word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xfer_cyc = 0;
  int t0       = 0;
  int done_cyc = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every RAM write away from the active edge.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      wr_addr_q.push_back(addra);
      wr_data_q.push_back(dina);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    start      = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one byte and hold it until a cycle with byte_ready high consumes it.
  task automatic send_byte(input logic [7:0] b);
    logic accepted;
    accepted   = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        xfer_cyc = cyc;
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
    end
    check_eq("byte_accepted", {31'd0, accepted}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    check_eq("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    // Test 1: reset state and a two-word load with byte_valid held high
    do_reset();
    @(negedge clk);
    check_eq("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wea", {31'd0, wea}, 32'd0);
    check_eq("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("rst_addra", {26'd0, addra}, 32'd0);
    check_eq("rst_dina", dina, 32'h0000_0000);
    check_eq("rst_word_cnt", {25'd0, word_cnt}, 32'd0);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(7'd2);
    @(negedge clk);
    check_eq("t1_ready_after_start", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h78);
    t0 = xfer_cyc;
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    byte_valid = 1'b0;
    wait_done(20);
    check_eq("t1_release_latency", done_cyc - t0, 32'd10);
    check_eq("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check_eq("t1_nwrites", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check_eq("t1_addr0", {26'd0, wr_addr_q[0]}, 32'd0);
      check_eq("t1_data0", wr_data_q[0], 32'h1234_5678);
      check_eq("t1_addr1", {26'd0, wr_addr_q[1]}, 32'd1);
      check_eq("t1_data1", wr_data_q[1], 32'hDEAD_BEEF);
    end
    check_eq("t1_word_cnt", {25'd0, word_cnt}, 32'd2);

    // Test 6: reload from DONE
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(7'd1);
    @(negedge clk);
    check_eq("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check_eq("t6_done", {31'd0, done}, 32'd0);
    check_eq("t6_word_cnt", {25'd0, word_cnt}, 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    byte_valid = 1'b0;
    wait_done(20);
    check_eq("t6_nwrites", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check_eq("t6_addr", {26'd0, wr_addr_q[0]}, 32'd0);
      check_eq("t6_data", wr_data_q[0], 32'h4433_2211);
    end

    // Test 2: toggled byte_valid for one word, then a byte held across WRITE
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(7'd2);
    send_byte(8'hDD);
    byte_valid = 1'b0; byte_in = 8'h00;
    @(posedge clk); #1;
    send_byte(8'hCC);
    byte_valid = 1'b0; byte_in = 8'h00;
    @(posedge clk); #1;
    send_byte(8'hBB);
    byte_valid = 1'b0; byte_in = 8'h00;
    @(posedge clk); #1;
    send_byte(8'hAA);
    byte_valid = 1'b1;
    byte_in    = 8'h88;
    @(negedge clk);
    check_eq("t2_ready_in_write", {31'd0, byte_ready}, 32'd0);
    check_eq("t2_wea_in_write", {31'd0, wea}, 32'd1);
    send_byte(8'h88);
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    byte_valid = 1'b0;
    wait_done(20);
    check_eq("t2_nwrites", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check_eq("t2_data0", wr_data_q[0], 32'hAABB_CCDD);
      check_eq("t2_addr1", {26'd0, wr_addr_q[1]}, 32'd1);
      check_eq("t2_data1", wr_data_q[1], 32'h5566_7788);
    end

    // Test 3: zero length from IDLE
    do_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(7'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("t3_done", {31'd0, done}, 32'd1);
    check_eq("t3_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check_eq("t3_nwrites", wr_addr_q.size(), 32'd0);

    // Test 4: len=100 clamps to a full 64-word RAM
    pulse_start(7'd100);
    for (int w = 0; w < 64; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(8'(w * 4 + k));
      end
    end
    byte_valid = 1'b0;
    wait_done(40);
    check_eq("t4_nwrites", wr_addr_q.size(), 32'd64);
    check_eq("t4_word_cnt", {25'd0, word_cnt}, 32'd64);
    if (wr_addr_q.size() == 64) begin
      for (int w = 0; w < 64; w++) begin
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(w * 4);
        b1 = 8'(w * 4 + 1);
        b2 = 8'(w * 4 + 2);
        b3 = 8'(w * 4 + 3);
        check_eq($sformatf("t4_addr%0d", w), {26'd0, wr_addr_q[w]}, 32'(w));
        check_eq($sformatf("t4_data%0d", w), wr_data_q[w], {b3, b2, b1, b0});
      end
    end

    // Test 5: reset after two bytes of the second word
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(7'd2);
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hB0);
    send_byte(8'hB1);
    byte_valid = 1'b0;
    do_reset();
    @(negedge clk);
    check_eq("t5_nwrites", wr_addr_q.size(), 32'd1);
    check_eq("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check_eq("t5_done", {31'd0, done}, 32'd0);
    check_eq("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("t5_word_cnt", {25'd0, word_cnt}, 32'd0);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(7'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    byte_valid = 1'b0;
    wait_done(20);
    check_eq("t5_reload_nwrites", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check_eq("t5_reload_addr", {26'd0, wr_addr_q[0]}, 32'd0);
      check_eq("t5_reload_data", wr_data_q[0], 32'h0403_0201);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
